// File: rtl/div_pkg.sv
// ============================================================================
// div_pkg : shared state encoding and Funct3 constants for the MDU divider
// Revision: 1.0
// ============================================================================
`default_nettype none

package div_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PREP  = 3'd1,
        ITER  = 3'd2,
        FIXUP = 3'd3,
        DONE  = 3'd4
    } div_state_e;

    localparam logic [2:0] FUNCT3_DIV  = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU = 3'b101;
    localparam logic [2:0] FUNCT3_REM  = 3'b110;
    localparam logic [2:0] FUNCT3_REMU = 3'b111;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// div_step : one combinational radix-2 restoring division iteration
// Revision: 1.0
// ============================================================================
`default_nettype none

module div_step
    import div_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN:0]   i_rem,
    input  logic [XLEN-1:0] i_quot,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN:0]   o_rem,
    output logic [XLEN-1:0] o_quot
);

    logic [XLEN+1:0] w_shifted;
    logic [XLEN+1:0] w_trial;
    logic            w_neg;

    // Two extra bits so the trial difference carries its own sign.
    assign w_shifted = {i_rem, i_quot[XLEN-1]};
    assign w_trial   = w_shifted - {2'b00, i_divisor};
    assign w_neg     = w_trial[XLEN+1];

    assign o_rem  = w_neg ? w_shifted[XLEN:0] : w_trial[XLEN:0];
    assign o_quot = {i_quot[XLEN-2:0], ~w_neg};

endmodule

`default_nettype wire

// File: rtl/div_seq.sv
// ============================================================================
// div_seq : iterative restoring divider (DIV/DIVU/REM/REMU), one bit per cycle
// Optional: DIV_EARLY_TERM_EN skips leading zeros of the dividend
// Revision: 1.0
// ============================================================================
`default_nettype none

module div_seq
    import div_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StartE,
    input  logic            FlushE,
    input  logic            StallM,
    input  logic [2:0]      Funct3E,
    input  logic [XLEN-1:0] ForwardedSrcAE,
    input  logic [XLEN-1:0] ForwardedSrcBE,
    output logic            DivBusyE,
    output logic            DivDoneM,
    output logic [XLEN-1:0] QuotM,
    output logic [XLEN-1:0] RemM,
    output logic [XLEN-1:0] DivResultM
);

    localparam int              CW      = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state_q, state_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [XLEN-1:0] q_q, q_d;
    logic [XLEN:0]   r_q, r_d;
    logic [XLEN-1:0] d_q, d_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            neg_quot_q, neg_quot_d;
    logic            neg_rem_q, neg_rem_d;
    logic [XLEN-1:0] quot_q, quot_d;
    logic [XLEN-1:0] rem_q, rem_d;

    logic            w_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;
    logic [XLEN:0]   w_step_r;
    logic [XLEN-1:0] w_step_q;
    logic            w_is_rem;

    // Operands are held raw until PREP, where they become magnitudes.
    assign w_signed = ~funct3_q[0];
    assign w_a_neg  = w_signed & q_q[XLEN-1];
    assign w_b_neg  = w_signed & d_q[XLEN-1];
    assign w_abs_a  = w_a_neg ? -q_q : q_q;
    assign w_abs_b  = w_b_neg ? -d_q : d_q;
    assign w_is_rem = (funct3_q == FUNCT3_REM) || (funct3_q == FUNCT3_REMU);

    div_step #(
        .XLEN      (XLEN)
    ) u_step (
        .i_rem     (r_q),
        .i_quot    (q_q),
        .i_divisor (d_q),
        .o_rem     (w_step_r),
        .o_quot    (w_step_q)
    );

`ifdef DIV_EARLY_TERM_EN
    logic [CW-1:0] w_lz;

    always_comb begin
        w_lz = '0;
        for (int i = 0; i < XLEN; i++) begin
            if (w_abs_a[i]) begin
                w_lz = CW'(XLEN - 1 - i);
            end
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        funct3_d   = funct3_q;
        q_d        = q_q;
        r_d        = r_q;
        d_d        = d_q;
        cnt_d      = cnt_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        quot_d     = quot_q;
        rem_d      = rem_q;

        if (FlushE) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (StartE) begin
                        q_d      = ForwardedSrcAE;
                        d_d      = ForwardedSrcBE;
                        funct3_d = Funct3E;
                        state_d  = PREP;
                    end
                end
                PREP: begin
                    neg_quot_d = w_a_neg ^ w_b_neg;
                    neg_rem_d  = w_a_neg;
                    r_d        = '0;
                    d_d        = w_abs_b;
                    if (d_q == '0) begin
                        quot_d  = '1;
                        rem_d   = q_q;
                        state_d = DONE;
                    end else if (w_signed && (q_q == MIN_NEG) && (d_q == '1)) begin
                        quot_d  = q_q;
                        rem_d   = '0;
                        state_d = DONE;
`ifdef DIV_EARLY_TERM_EN
                    end else if (q_q == '0) begin
                        quot_d  = '0;
                        rem_d   = '0;
                        state_d = DONE;
                    end else begin
                        q_d     = w_abs_a << w_lz;
                        cnt_d   = CW'(XLEN - 1) - w_lz;
                        state_d = ITER;
                    end
`else
                    end else begin
                        q_d     = w_abs_a;
                        cnt_d   = CW'(XLEN - 1);
                        state_d = ITER;
                    end
`endif
                end
                ITER: begin
                    r_d   = w_step_r;
                    q_d   = w_step_q;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        state_d = FIXUP;
                    end
                end
                FIXUP: begin
                    quot_d  = neg_quot_q ? -q_q : q_q;
                    rem_d   = neg_rem_q ? -r_q[XLEN-1:0] : r_q[XLEN-1:0];
                    state_d = DONE;
                end
                DONE: begin
                    if (!StallM) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            funct3_q   <= '0;
            q_q        <= '0;
            r_q        <= '0;
            d_q        <= '0;
            cnt_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
        end else begin
            state_q    <= state_d;
            funct3_q   <= funct3_d;
            q_q        <= q_d;
            r_q        <= r_d;
            d_q        <= d_d;
            cnt_q      <= cnt_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
        end
    end

    assign DivBusyE   = (state_q == PREP) || (state_q == ITER) || (state_q == FIXUP);
    assign DivDoneM   = (state_q == DONE);
    assign QuotM      = quot_q;
    assign RemM       = rem_q;
    assign DivResultM = w_is_rem ? rem_q : quot_q;

endmodule

`default_nettype wire

// File: tb/tb_div_seq.sv
// ============================================================================
// tb_div_seq : directed scoreboard bench for div_seq at XLEN=32
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_div_seq;

    localparam int XLEN = 32;

    logic            clk;
    logic            reset;
    logic            StartE;
    logic            FlushE;
    logic            StallM;
    logic [2:0]      Funct3E;
    logic [XLEN-1:0] ForwardedSrcAE;
    logic [XLEN-1:0] ForwardedSrcBE;
    logic            DivBusyE;
    logic            DivDoneM;
    logic [XLEN-1:0] QuotM;
    logic [XLEN-1:0] RemM;
    logic [XLEN-1:0] DivResultM;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
        logic        rem_sel;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_q;
    logic [31:0] last_r;

    div_seq #(
        .XLEN           (XLEN)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .StartE         (StartE),
        .FlushE         (FlushE),
        .StallM         (StallM),
        .Funct3E        (Funct3E),
        .ForwardedSrcAE (ForwardedSrcAE),
        .ForwardedSrcBE (ForwardedSrcBE),
        .DivBusyE       (DivBusyE),
        .DivDoneM       (DivDoneM),
        .QuotM          (QuotM),
        .RemM           (RemM),
        .DivResultM     (DivResultM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("%s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Edges counted from the StartE sample edge (that edge counts as 1).
    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic        sgn;
        logic [31:0] mag;
        int          msb;
        sgn = ~f3[0];
        if (b == 32'd0) return 2;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        mag = (sgn && a[31]) ? (32'd0 - a) : a;
        msb = -1;
        for (int i = 0; i < 32; i++) if (mag[i]) msb = i;
`ifdef DIV_EARLY_TERM_EN
        if (mag == 32'd0) return 2;
        return msb + 1 + 3;
`else
        if (msb < -1) return 0;
        return XLEN + 3;
`endif
    endfunction

    function automatic void model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
        logic sgn;
        sgn = ~f3[0];
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 32'd0;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input int stall);
        exp_t e;
        int   lat;
        sb.push_back('{eq, er, exp_lat(f3, a, b), f3[1]});
        @(negedge clk);
        Funct3E        = f3;
        ForwardedSrcAE = a;
        ForwardedSrcBE = b;
        StallM         = (stall > 0);
        StartE         = 1'b1;
        @(posedge clk);
        #1;
        StartE = 1'b0;
        lat    = 1;
        check("busy_prep", {31'd0, DivBusyE}, 32'd1);
        while (DivDoneM !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e = sb.pop_front();
        check("latency", lat, e.lat);
        check("quot", QuotM, e.q);
        check("rem", RemM, e.r);
        check("result", DivResultM, e.rem_sel ? e.r : e.q);
        check("busy_done", {31'd0, DivBusyE}, 32'd0);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check("stall_hold", {31'd0, DivDoneM}, 32'd1);
            check("stall_quot", QuotM, e.q);
        end
        StallM = 1'b0;
        @(posedge clk);
        #1;
        check("done_exit", {31'd0, DivDoneM}, 32'd0);
        check("idle_quot", QuotM, e.q);
        last_q = e.q;
        last_r = e.r;
    endtask

    initial begin
        logic [31:0] ra, rb, mq, mr;
        logic [2:0]  rf;
        int          sel;
        logic        saw_done;

        reset          = 1'b0;
        StartE         = 1'b0;
        FlushE         = 1'b0;
        StallM         = 1'b0;
        Funct3E        = 3'b000;
        ForwardedSrcAE = '0;
        ForwardedSrcBE = '0;
        last_q         = '0;
        last_r         = '0;

        #12;
        check("rst_busy", {31'd0, DivBusyE}, 32'd0);
        check("rst_done", {31'd0, DivDoneM}, 32'd0);
        check("rst_quot", QuotM, 32'd0);
        check("rst_rem", RemM, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op(3'b101, 32'd100, 32'd7, 32'd14, 32'd2, 3);
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
        run_op(3'b110, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 0);
        run_op(3'b100, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 0);
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0);
        run_op(3'b111, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 0);
        run_op(3'b101, 32'd5, 32'd1, 32'd5, 32'd0, 0);
        run_op(3'b101, 32'd0, 32'd5, 32'd0, 32'd0, 0);
        run_op(3'b101, 32'd3, 32'd10, 32'd0, 32'd3, 0);

        // Flush in the middle of iteration.
        @(negedge clk);
        Funct3E        = 3'b101;
        ForwardedSrcAE = 32'hFFFF_FFFF;
        ForwardedSrcBE = 32'd3;
        StartE         = 1'b1;
        @(posedge clk);
        #1;
        StartE = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        check("iter_busy", {31'd0, DivBusyE}, 32'd1);
        FlushE = 1'b1;
        @(posedge clk);
        #1;
        FlushE = 1'b0;
        check("flush_busy", {31'd0, DivBusyE}, 32'd0);
        check("flush_done", {31'd0, DivDoneM}, 32'd0);
        check("flush_quot", QuotM, last_q);
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (DivDoneM !== 1'b0) saw_done = 1'b1;
        end
        check("flush_never_done", {31'd0, saw_done}, 32'd0);

        // Asynchronous reset during iteration.
        @(negedge clk);
        Funct3E        = 3'b100;
        ForwardedSrcAE = 32'h7FFF_0000;
        ForwardedSrcBE = 32'd7;
        StartE         = 1'b1;
        @(posedge clk);
        #1;
        StartE = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("arst_busy", {31'd0, DivBusyE}, 32'd0);
        check("arst_quot", QuotM, 32'd0);
        check("arst_rem", RemM, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op(3'b101, 32'd9, 32'd3, 32'd3, 32'd0, 0);

        for (int k = 0; k < 6; k++) begin
            ra  = $urandom;
            rb  = $urandom >> $urandom_range(0, 28);
            sel = $urandom_range(0, 3);
            rf  = 3'b100 | 3'(sel);
            model(rf, ra, rb, mq, mr);
            run_op(rf, ra, rb, mq, mr, k % 2);
        end

        check("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/div_seq.md
Name: div_seq

Overview:
- Iterative radix-2 restoring integer divider for the MDU.
- Implements the inverse operation of the pipelined multiplier: RISC-V DIV, DIVU, REM and REMU.
- Issued from Execute. It holds the pipeline busy during iteration and presents quotient and remainder to Memory.
- One quotient bit per cycle. Shares the MDU operand and Funct3 encoding.

Parameters:
- XLEN, 64, operand and result width (32 or 64).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- StartE  input  1  request: start a division with the current operands (sampled only in IDLE)
- FlushE  input  1  abort any operation in progress; return to IDLE next cycle
- StallM  input  1  hold the completed result in DONE
- Funct3E  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU
- ForwardedSrcAE  input  XLEN  dividend
- ForwardedSrcBE  input  XLEN  divisor
- DivBusyE  output  1  high in PREP, ITER and FIXUP; the pipeline stalls on it
- DivDoneM  output  1  high only in DONE
- QuotM  output  XLEN  quotient
- RemM  output  XLEN  remainder
- DivResultM  output  XLEN  QuotM for Funct3[1]=0, RemM for Funct3[1]=1

Behaviour:
- Reset, while reset is low and asynchronously: state=IDLE, DivBusyE=0, DivDoneM=0, QuotM=0, RemM=0, iteration counter=0.
- States: IDLE, PREP, ITER, FIXUP, DONE. Transitions:
  - IDLE→PREP on StartE. Operands and Funct3E are latched.
  - PREP: compute signed = ~Funct3[0]; take absolute values of the operands when signed.
    - Divisor==0 → DONE with Quot = all-ones, Rem = dividend.
    - Signed overflow (dividend = −2^(XLEN−1), divisor = −1) → DONE with Quot = dividend, Rem = 0.
    - Otherwise → ITER with counter = XLEN−1.
  - ITER, each cycle:
    - Shift the {R,Q} pair left by one and trial-subtract the divisor from R.
    - If the result is non-negative, R takes the difference and the Q LSB = 1; otherwise R is unchanged and the Q LSB = 0.
    - Decrement the counter. At 0 → FIXUP.
  - FIXUP: when signed, negate Q if the operand signs differ, and negate R if the dividend is negative. → DONE.
  - DONE: DivDoneM=1 and the outputs are valid. If StallM=1, stay in DONE. Otherwise → IDLE.
- Latency:
  - Normal case: DivDoneM rises XLEN+3 cycles after the StartE sample edge (PREP 1 + ITER XLEN + FIXUP 1 + 1 edge into DONE).
  - Special cases (divide by zero, overflow): DivDoneM rises 2 cycles after the StartE sample edge.
- StartE outside IDLE is ignored. A new StartE in the same cycle that DONE exits is not accepted until IDLE.
- FlushE has priority over all transitions, including DONE→IDLE. QuotM and RemM keep stale values after a flush; DivDoneM=0.
- Reset mid-operation: immediate return to IDLE with the reset values above.
- Remainder register width is XLEN+1 bits so the trial subtraction sign bit is available. The quotient shares the dividend register.
- QuotM and RemM update only on entering DONE. They are stable while in DONE and IDLE.

Optional Feature:
- Macro: DIV_EARLY_TERM_EN.
- When defined:
  - PREP counts leading zeros of |dividend| (lz) and pre-shifts the dividend left by lz.
  - ITER runs XLEN−lz cycles.
  - A dividend of 0 goes straight to DONE with Quot=0, Rem=0.
  - Latency becomes (XLEN−lz)+3.
- When undefined: fixed latency as stated above, and no count-leading-zeros logic is present.

Decomposition:
- Shared package div_pkg: the state enum (IDLE, PREP, ITER, FIXUP, DONE) and the Funct3 constants (FUNCT3_DIV, FUNCT3_DIVU, FUNCT3_REM, FUNCT3_REMU).
- One sub-module, div_step: a combinational single restoring iteration. Inputs are R, Q and the divisor; outputs are the next R and the next Q.

Test Plan (XLEN=32):
- DIVU 100/7: StartE → DivDoneM at cycle 35, QuotM=14, RemM=2; with StallM=1, DONE holds until it is released.
- DIV −7/2: QuotM=−3 (0xFFFFFFFD), RemM=−1; REM −7/−2 gives RemM=−1 and QuotM=3.
- Divide by zero, DIV 0x12345678/0: done in 2 cycles, QuotM=0xFFFFFFFF, RemM=0x12345678.
- Overflow, DIV 0x80000000/0xFFFFFFFF: done in 2 cycles, QuotM=0x80000000, RemM=0.
- Abort: assert FlushE at ITER cycle 10 → IDLE next cycle, DivDoneM never rises. Pull reset low in ITER → outputs go to 0 immediately. A following DIVU 9/3 completes correctly with Quot=3, Rem=0.
- DIV_EARLY_TERM_EN defined: DIVU 5/1 (lz=29) → done in 6 cycles, QuotM=5, RemM=0. A dividend of 0 → Quot=0, Rem=0 in 2 cycles.
